// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between the two data-RAM requesters (memory stage A, secondary master B)
// and the data-RAM arbiter. Addresses are full ALU width; the arbiter truncates them.
interface dmem_arbiter_if #(
    parameter int DATA_W = 18
);
    logic              a_req;
    logic              a_we;
    logic [17:0]       a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_stall;
    logic [DATA_W-1:0] a_rdata;
    logic              a_rvalid;

    logic              b_req;
    logic              b_we;
    logic [17:0]       b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic [DATA_W-1:0] b_rdata;
    logic              b_rvalid;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_stall, a_rdata, a_rvalid,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rdata, b_rvalid
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_stall, a_rdata, a_rvalid,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rdata, b_rvalid
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port synchronous-read data RAM between the memory stage (A) and a secondary master (B).
// Define DMEM_ARB_STARVE_GUARD_EN to force B through after MAX_WAIT consecutive refusals.
module dmem_arbiter #(
    parameter int DATA_W   = 18,
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     bus,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);
    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;

    owner_t rd_owner_reg;
    owner_t rd_owner_next;
    logic   grant_a;
    logic   grant_b;
    logic   force_b;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [WAIT_W-1:0] wait_cnt_next;

    assign force_b = bus.b_req && (wait_cnt_reg == WAIT_W'(MAX_WAIT));

    always_comb begin
        wait_cnt_next = '0;
        if (bus.b_req && !grant_b) begin
            wait_cnt_next = (wait_cnt_reg == WAIT_W'(MAX_WAIT)) ? wait_cnt_reg
                                                                : wait_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end
`else
    localparam int unused_max_wait = MAX_WAIT;

    assign force_b = 1'b0;
`endif

    // Grants are suppressed while reset is held so nothing reaches the RAM.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst) begin
            if (force_b) begin
                grant_b = 1'b1;
            end else if (bus.a_req) begin
                grant_a = 1'b1;
            end else if (bus.b_req) begin
                grant_b = 1'b1;
            end
        end
    end

    assign bus.b_gnt   = grant_b;
    assign bus.a_stall = rst && bus.a_req && !grant_a;

    assign ram_address = grant_b ? bus.b_addr[ADDR_W-1:0] : bus.a_addr[ADDR_W-1:0];
    assign ram_data    = grant_b ? bus.b_wdata : bus.a_wdata;
    assign ram_wren    = (grant_a && bus.a_we) || (grant_b && bus.b_we);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.a_addr[17:ADDR_W], bus.b_addr[17:ADDR_W]};

    always_comb begin
        rd_owner_next = OWN_NONE;
        if (grant_a && !bus.a_we) begin
            rd_owner_next = OWN_A;
        end else if (grant_b && !bus.b_we) begin
            rd_owner_next = OWN_B;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_owner_reg <= OWN_NONE;
        end else begin
            rd_owner_reg <= rd_owner_next;
        end
    end

    // Index 0 is port A, index 1 is port B. RAM data passes straight through in the
    // owner's cycle and is held afterwards so a non-owner keeps its last word.
    logic [1:0]             rvalid;
    logic [1:0][DATA_W-1:0] rdata;

    assign rvalid[0] = (rd_owner_reg == OWN_A);
    assign rvalid[1] = (rd_owner_reg == OWN_B);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_W-1:0] hold_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    hold_reg <= '0;
                end else if (rvalid[gi]) begin
                    hold_reg <= ram_q;
                end
            end

            assign rdata[gi] = rvalid[gi] ? ram_q : hold_reg;
        end
    endgenerate

    assign bus.a_rvalid = rvalid[0];
    assign bus.a_rdata  = rdata[0];
    assign bus.b_rvalid = rvalid[1];
    assign bus.b_rdata  = rdata[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: reset, directed vector table, contention/reset sequences, then
// randomized traffic checked against a behavioural model of the RAM and the grant rules.
module tb_dmem_arbiter;
    localparam int DATA_W   = 18;
    localparam int ADDR_W   = 10;
    localparam int MAX_WAIT = 4;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    dmem_arbiter_if #(.DATA_W(DATA_W)) bus ();

    dmem_arbiter #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .ram_address(ram_address),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .ram_q      (ram_q)
    );

    // Synchronous-read single-port RAM driven only by the arbiter.
    logic [DATA_W-1:0] ram_mem [1 << ADDR_W];
    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_address] <= ram_data;
        ram_q <= ram_mem[ram_address];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks;
    int errors;
    int cyc;

    // Behavioural model: memory contents, the read in flight, and B's consecutive refusals.
    logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
    int                refused;
    int                pend;      // 0 none, 1 port A, 2 port B
    logic [DATA_W-1:0] pend_data;
    logic [DATA_W-1:0] last_a;
    logic [DATA_W-1:0] last_b;
    logic              last_gb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        refused = 0;
        pend    = 0;
        last_a  = '0;
        last_b  = '0;
        last_gb = 1'b0;
    endtask

    task automatic model_decide(output logic ga, output logic gb);
        logic forced;
        forced = 1'b0;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        forced = bus.b_req && (refused >= MAX_WAIT);
`endif
        ga = 1'b0;
        gb = 1'b0;
        if (rst) begin
            if (forced)         gb = 1'b1;
            else if (bus.a_req) ga = 1'b1;
            else if (bus.b_req) gb = 1'b1;
        end
    endtask

    task automatic model_advance();
        logic ga, gb;
        if (!rst) begin
            model_reset();
            return;
        end
        model_decide(ga, gb);
        if (pend == 1) last_a = pend_data;
        if (pend == 2) last_b = pend_data;
        pend = 0;
        if (ga) begin
            if (bus.a_we) ref_mem[bus.a_addr[ADDR_W-1:0]] = bus.a_wdata;
            else begin pend = 1; pend_data = ref_mem[bus.a_addr[ADDR_W-1:0]]; end
        end else if (gb) begin
            if (bus.b_we) ref_mem[bus.b_addr[ADDR_W-1:0]] = bus.b_wdata;
            else begin pend = 2; pend_data = ref_mem[bus.b_addr[ADDR_W-1:0]]; end
        end
        refused = (bus.b_req && !gb) ? refused + 1 : 0;
        last_gb = gb;
    endtask

    task automatic model_check();
        logic ga, gb;
        model_decide(ga, gb);
        chk("b_gnt", bus.b_gnt, gb);
        chk("a_stall", bus.a_stall, rst && bus.a_req && !ga);
        chk("ram_wren", ram_wren, (ga && bus.a_we) || (gb && bus.b_we));
        if (ga) chk("ram_addr_a", ram_address, bus.a_addr[ADDR_W-1:0]);
        if (gb) chk("ram_addr_b", ram_address, bus.b_addr[ADDR_W-1:0]);
        if (ga && bus.a_we) chk("ram_data_a", ram_data, bus.a_wdata);
        if (gb && bus.b_we) chk("ram_data_b", ram_data, bus.b_wdata);
        chk("a_rvalid", bus.a_rvalid, pend == 1);
        chk("a_rdata", bus.a_rdata, (pend == 1) ? pend_data : last_a);
        chk("b_rvalid", bus.b_rvalid, pend == 2);
        chk("b_rdata", bus.b_rdata, (pend == 2) ? pend_data : last_b);
    endtask

    // Called at the negedge: log the cycle, cross the active edge, update the model.
    task automatic finish_cycle();
        $display("cyc %0d rst=%b A(req=%b we=%b addr=%h) B(req=%b we=%b addr=%h) gnt=%b stall=%b wren=%b arv=%b ard=%h brv=%b brd=%h",
                 cyc, rst, bus.a_req, bus.a_we, bus.a_addr, bus.b_req, bus.b_we, bus.b_addr,
                 bus.b_gnt, bus.a_stall, ram_wren, bus.a_rvalid, bus.a_rdata, bus.b_rvalid, bus.b_rdata);
        @(posedge clk);
        model_advance();
        #1;
        cyc++;
    endtask

    task automatic drive(input logic ar, input logic aw, input logic [17:0] aa, input logic [17:0] ad,
                         input logic br, input logic bw, input logic [17:0] ba, input logic [17:0] bd);
        bus.a_req = ar; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
        bus.b_req = br; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd;
    endtask

    typedef struct {
        logic        a_req, a_we;
        logic [17:0] a_addr, a_wdata;
        logic        b_req, b_we;
        logic [17:0] b_addr, b_wdata;
        logic        gnt, stall, wren, arv;
        logic [17:0] ard;
        logic        brv;
        logic [17:0] brd;
    } vec_t;

    vec_t vecs [19];

    initial begin
        vecs[0]  = '{1'b1,1'b1,18'h00005,18'h2AAAA, 1'b0,1'b0,18'h0,18'h0,         1'b0,1'b0,1'b1, 1'b0,18'h00000, 1'b0,18'h00000};
        vecs[1]  = '{1'b1,1'b0,18'h00005,18'h0,     1'b0,1'b0,18'h0,18'h0,         1'b0,1'b0,1'b0, 1'b0,18'h00000, 1'b0,18'h00000};
        vecs[2]  = '{1'b0,1'b0,18'h0,18'h0,         1'b0,1'b0,18'h0,18'h0,         1'b0,1'b0,1'b0, 1'b1,18'h2AAAA, 1'b0,18'h00000};
        vecs[3]  = '{1'b1,1'b1,18'h00007,18'h00123, 1'b0,1'b0,18'h0,18'h0,         1'b0,1'b0,1'b1, 1'b0,18'h2AAAA, 1'b0,18'h00000};
        vecs[4]  = '{1'b0,1'b0,18'h0,18'h0,         1'b1,1'b0,18'h00007,18'h0,     1'b1,1'b0,1'b0, 1'b0,18'h2AAAA, 1'b0,18'h00000};
        vecs[5]  = '{1'b0,1'b0,18'h0,18'h0,         1'b0,1'b0,18'h0,18'h0,         1'b0,1'b0,1'b0, 1'b0,18'h2AAAA, 1'b1,18'h00123};
        vecs[6]  = '{1'b1,1'b1,18'h00009,18'h11111, 1'b1,1'b1,18'h00009,18'h22222, 1'b0,1'b0,1'b1, 1'b0,18'h2AAAA, 1'b0,18'h00123};
        vecs[7]  = '{1'b1,1'b0,18'h00009,18'h0,     1'b0,1'b0,18'h0,18'h0,         1'b0,1'b0,1'b0, 1'b0,18'h2AAAA, 1'b0,18'h00123};
        vecs[8]  = '{1'b0,1'b0,18'h0,18'h0,         1'b0,1'b0,18'h0,18'h0,         1'b0,1'b0,1'b0, 1'b1,18'h11111, 1'b0,18'h00123};
        vecs[9]  = '{1'b1,1'b0,18'h3FC05,18'h0,     1'b0,1'b0,18'h0,18'h0,         1'b0,1'b0,1'b0, 1'b0,18'h11111, 1'b0,18'h00123};
        vecs[10] = '{1'b0,1'b0,18'h0,18'h0,         1'b0,1'b0,18'h0,18'h0,         1'b0,1'b0,1'b0, 1'b1,18'h2AAAA, 1'b0,18'h00123};
        vecs[11] = '{1'b0,1'b0,18'h0,18'h0,         1'b1,1'b1,18'h00C07,18'h3FFFF, 1'b1,1'b0,1'b1, 1'b0,18'h2AAAA, 1'b0,18'h00123};
        vecs[12] = '{1'b1,1'b0,18'h00007,18'h0,     1'b1,1'b0,18'h00005,18'h0,     1'b0,1'b0,1'b0, 1'b0,18'h2AAAA, 1'b0,18'h00123};
        vecs[13] = '{1'b0,1'b0,18'h0,18'h0,         1'b1,1'b0,18'h00005,18'h0,     1'b1,1'b0,1'b0, 1'b1,18'h3FFFF, 1'b0,18'h00123};
        vecs[14] = '{1'b1,1'b0,18'h00005,18'h0,     1'b0,1'b0,18'h0,18'h0,         1'b0,1'b0,1'b0, 1'b0,18'h3FFFF, 1'b1,18'h2AAAA};
        vecs[15] = '{1'b1,1'b0,18'h00007,18'h0,     1'b0,1'b0,18'h0,18'h0,         1'b0,1'b0,1'b0, 1'b1,18'h2AAAA, 1'b0,18'h2AAAA};
        vecs[16] = '{1'b1,1'b1,18'h00005,18'h15555, 1'b0,1'b0,18'h0,18'h0,         1'b0,1'b0,1'b1, 1'b1,18'h3FFFF, 1'b0,18'h2AAAA};
        vecs[17] = '{1'b1,1'b0,18'h00005,18'h0,     1'b0,1'b0,18'h0,18'h0,         1'b0,1'b0,1'b0, 1'b0,18'h3FFFF, 1'b0,18'h2AAAA};
        vecs[18] = '{1'b0,1'b0,18'h0,18'h0,         1'b0,1'b0,18'h0,18'h0,         1'b0,1'b0,1'b0, 1'b1,18'h15555, 1'b0,18'h2AAAA};

        checks = 0;
        errors = 0;
        cyc    = 0;
        model_reset();
        drive(1'b0, 1'b0, 18'h0, 18'h0, 1'b0, 1'b0, 18'h0, 18'h0);
        rst = 1'b1;
        #2 rst = 1'b0;

        // Reset held while both ports try to write.
        drive(1'b1, 1'b1, 18'h00005, 18'h3FFFF, 1'b1, 1'b1, 18'h00007, 18'h3FFFF);
        repeat (3) begin
            @(negedge clk);
            chk("rst_wren", ram_wren, 0);
            chk("rst_b_gnt", bus.b_gnt, 0);
            chk("rst_a_stall", bus.a_stall, 0);
            chk("rst_a_rvalid", bus.a_rvalid, 0);
            chk("rst_b_rvalid", bus.b_rvalid, 0);
            chk("rst_a_rdata", bus.a_rdata, 0);
            chk("rst_b_rdata", bus.b_rdata, 0);
            finish_cycle();
        end
        drive(1'b0, 1'b0, 18'h0, 18'h0, 1'b0, 1'b0, 18'h0, 18'h0);
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].a_req, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wdata,
                  vecs[i].b_req, vecs[i].b_we, vecs[i].b_addr, vecs[i].b_wdata);
            @(negedge clk);
            chk($sformatf("v%0d_b_gnt", i), bus.b_gnt, vecs[i].gnt);
            chk($sformatf("v%0d_a_stall", i), bus.a_stall, vecs[i].stall);
            chk($sformatf("v%0d_wren", i), ram_wren, vecs[i].wren);
            chk($sformatf("v%0d_a_rvalid", i), bus.a_rvalid, vecs[i].arv);
            chk($sformatf("v%0d_a_rdata", i), bus.a_rdata, vecs[i].ard);
            chk($sformatf("v%0d_b_rvalid", i), bus.b_rvalid, vecs[i].brv);
            chk($sformatf("v%0d_b_rdata", i), bus.b_rdata, vecs[i].brd);
            finish_cycle();
        end

        // Contention builds up B's wait, then reset lands right after an A read grant.
        drive(1'b1, 1'b0, 18'h00005, 18'h0, 1'b1, 1'b0, 18'h00007, 18'h0);
        repeat (3) begin
            @(negedge clk);
            chk("pre_rst_b_gnt", bus.b_gnt, 0);
            finish_cycle();
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("mid_rst_a_rvalid", bus.a_rvalid, 0);
        chk("mid_rst_b_rvalid", bus.b_rvalid, 0);
        chk("mid_rst_a_rdata", bus.a_rdata, 0);
        finish_cycle();
        rst = 1'b1;

`ifdef DMEM_ARB_STARVE_GUARD_EN
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) chk("post_rst_a_rvalid", bus.a_rvalid, 0);
            chk($sformatf("cont%0d_b_gnt", c), bus.b_gnt, (c == 4) ? 32'd1 : 32'd0);
            chk($sformatf("cont%0d_a_stall", c), bus.a_stall, (c == 4) ? 32'd1 : 32'd0);
            finish_cycle();
        end
`else
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) chk("post_rst_a_rvalid", bus.a_rvalid, 0);
            chk($sformatf("cont%0d_b_gnt", c), bus.b_gnt, 0);
            chk($sformatf("cont%0d_a_stall", c), bus.a_stall, 0);
            finish_cycle();
        end
        bus.a_req = 1'b0;
        @(negedge clk);
        chk("a_drop_b_gnt", bus.b_gnt, 1);
        finish_cycle();
`endif

        // Preload the random working set, then random traffic against the model.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 18'(i), 18'($urandom), 1'b0, 1'b0, 18'h0, 18'h0);
            @(negedge clk);
            model_check();
            finish_cycle();
        end
        bus.b_req = 1'b0;
        for (int n = 0; n < 300; n++) begin
            bus.a_req   = ($urandom_range(0, 9) < 6);
            bus.a_we    = 1'($urandom);
            bus.a_addr  = {8'($urandom), 6'b0, 4'($urandom)};
            bus.a_wdata = 18'($urandom);
            if (bus.b_req && !last_gb) begin
                if ($urandom_range(0, 15) == 0) bus.b_req = 1'b0;
            end else begin
                bus.b_req   = 1'($urandom);
                bus.b_we    = 1'($urandom);
                bus.b_addr  = {8'($urandom), 6'b0, 4'($urandom)};
                bus.b_wdata = 18'($urandom);
            end
            @(negedge clk);
            model_check();
            finish_cycle();
        end
        drive(1'b0, 1'b0, 18'h0, 18'h0, 1'b0, 1'b0, 18'h0, 18'h0);
        @(negedge clk);
        model_check();
        finish_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
